scan_chain_ctrl: RTL

//  Sequences dump/restore of one DUT scan chain. Dump streams chain contents
//  out as WORD_W-bit words and recirculates them, so the dump is non-destructive.

---
 rtl/scan_chain_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/scan_chain_ctrl.sv
// Scan chain dump/restore sequencer: streams one DUT scan chain out as words
// (recirculating so the dump is non-destructive) or shifts host words back in.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 24,
    parameter int WORD_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_op_i,
    output logic              dut_en_o,
    output logic              scan_en_o,
    output logic              scan_in_o,
    input  logic              scan_out_i,
    output logic              rdata_valid_o,
    input  logic              rdata_ready_i,
    output logic [WORD_W-1:0] rdata_o,
    input  logic              wdata_valid_i,
    output logic              wdata_ready_o,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int CNT_W     = $clog2(WORD_W + 1);
    localparam int WCNT_W    = $clog2(NWORDS + 1);
    localparam int IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  LAST_M1   = CNT_W'(LAST_BITS - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic               op_reg, op_next;
    logic [WORD_W-1:0]  buf_reg, buf_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [WCNT_W-1:0]  word_cnt_reg, word_cnt_next;

    logic               last_word;
    logic               last_bit;
    logic [IDX_W-1:0]   bit_idx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_IDLE;
            op_reg       <= 1'b0;
            buf_reg      <= '0;
            bit_cnt_reg  <= '0;
            word_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            buf_reg      <= buf_next;
            bit_cnt_reg  <= bit_cnt_next;
            word_cnt_reg <= word_cnt_next;
        end
    end

    // The final word may be shorter than WORD_W, so the shift length depends on it
    assign last_word = (word_cnt_reg == LAST_WORD);
    assign last_bit  = last_word ? (bit_cnt_reg == LAST_M1) : (bit_cnt_reg == FULL_M1);
    assign bit_idx   = bit_cnt_reg[IDX_W-1:0];

    assign rdata_o = buf_reg;
    assign busy_o  = (state_reg != ST_IDLE);

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        buf_next      = buf_reg;
        bit_cnt_next  = bit_cnt_reg;
        word_cnt_next = word_cnt_reg;
        cmd_ready_o   = 1'b0;
        dut_en_o      = 1'b0;
        scan_en_o     = 1'b0;
        scan_in_o     = 1'b0;
        rdata_valid_o = 1'b0;
        wdata_ready_o = 1'b0;
        done_o        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                dut_en_o    = 1'b1;
                if (cmd_valid_i) begin
                    op_next       = cmd_op_i;
                    bit_cnt_next  = '0;
                    word_cnt_next = '0;
                    buf_next      = '0;
                    state_next    = cmd_op_i ? ST_LOAD : ST_SHIFT;
                end
            end
            ST_LOAD: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    buf_next   = wdata_i;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scan_en_o = 1'b1;
                if (op_reg) begin
                    scan_in_o = buf_reg[bit_idx];
                end else begin
                    // Head bit goes straight back into the tail so the chain survives the dump
                    scan_in_o         = scan_out_i;
                    buf_next[bit_idx] = scan_out_i;
                end
                if (last_bit) begin
                    bit_cnt_next = '0;
                    if (!op_reg) begin
                        state_next = ST_EMIT;
                    end else if (last_word) begin
                        state_next = ST_DONE;
                    end else begin
                        word_cnt_next = word_cnt_reg + WCNT_W'(1);
                        state_next    = ST_LOAD;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end
            ST_EMIT: begin
                rdata_valid_o = 1'b1;
                if (rdata_ready_i) begin
                    if (last_word) begin
                        state_next = ST_DONE;
                    end else begin
                        word_cnt_next = word_cnt_reg + WCNT_W'(1);
                        buf_next      = '0;
                        state_next    = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                done_o     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
